// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        FULL = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, issues one outstanding imem request and
// feeds a registered slot into IF/ID, honouring stall and branch redirect.
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP      = NOP_INSTR
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            branch_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ready_i,
    input  logic            imem_valid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic            valid_o,
    output logic            flush_o
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] issued_pc_q, issued_pc_d;
    logic            kill_q, kill_d;
    fetch_entry_t    buf_q, buf_d;
    fetch_entry_t    slot_q, slot_d;
    logic            valid_q, valid_d;

    logic            slot_free;
    logic [XLEN-1:0] target;
    fetch_entry_t    bubble;

    assign target    = branch_target_i & ~32'h3;
    assign bubble    = '{instr: NOP, pc: '0};
    assign slot_free = !valid_q || !stall_i;

    assign flush_o     = branch_i;
    // Redirect masks the request so the stale pc_q never reaches memory.
    assign imem_req_o  = (state_q == REQ) && !branch_i;
    assign imem_addr_o = pc_q;

    assign valid_o = valid_q;
    assign instr_o = slot_q.instr;
    assign pc_o    = slot_q.pc;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        issued_pc_d = issued_pc_q;
        kill_d      = kill_q;
        buf_d       = buf_q;
        valid_d     = valid_q;
        slot_d      = slot_q;

        // An advancing pipeline drains the slot unless something loads it below.
        if (!stall_i) begin
            valid_d = 1'b0;
            slot_d  = bubble;
        end

        if (branch_i) begin
            pc_d    = target;
            valid_d = 1'b0;
            slot_d  = bubble;
            buf_d   = '0;
            case (state_q)
                WAIT: begin
                    if (imem_valid_i) begin
                        state_d = REQ;
                        kill_d  = 1'b0;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end
                default: state_d = REQ;
            endcase
        end else begin
            case (state_q)
                REQ: begin
                    if (imem_req_o && imem_ready_i) begin
                        issued_pc_d = pc_q;
                        pc_d        = pc_q + PC_STEP;
                        state_d     = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_valid_i) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = REQ;
                        end else if (slot_free) begin
                            valid_d = 1'b1;
                            slot_d  = '{instr: imem_rdata_i, pc: issued_pc_q};
                            state_d = REQ;
                        end else begin
                            buf_d   = '{instr: imem_rdata_i, pc: issued_pc_q};
                            state_d = FULL;
                        end
                    end
                end
                FULL: begin
                    if (!stall_i) begin
                        valid_d = 1'b1;
                        slot_d  = buf_q;
                        state_d = REQ;
                    end
                end
                default: state_d = REQ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= REQ;
            pc_q        <= RESET_PC;
            issued_pc_q <= '0;
            kill_q      <= 1'b0;
            buf_q       <= '0;
            valid_q     <= 1'b0;
            slot_q      <= '{instr: NOP, pc: '0};
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            issued_pc_q <= issued_pc_d;
            kill_q      <= kill_d;
            buf_q       <= buf_d;
            valid_q     <= valid_d;
            slot_q      <= slot_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: streaming, stall/buffer, redirect, wrap, reset.
module tb_if_fetch_unit;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        branch_i;
    logic [31:0] branch_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic        imem_valid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        flush_o;

    int n_checks = 0;
    int n_fails  = 0;

    if_fetch_unit dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .branch_i(branch_i),
        .branch_target_i(branch_target_i), .imem_req_o(imem_req_o),
        .imem_addr_o(imem_addr_o), .imem_ready_i(imem_ready_i),
        .imem_valid_i(imem_valid_i), .imem_rdata_i(imem_rdata_i),
        .instr_o(instr_o), .pc_o(pc_o), .valid_o(valid_o), .flush_o(flush_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; stall_i = 1'b0; branch_i = 1'b0; branch_target_i = '0;
        imem_ready_i = 1'b0; imem_valid_i = 1'b0; imem_rdata_i = '0;
        tick(); tick();
        rst_i = 1'b0; #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (valid_o !== 1'b0) begin n_fails++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_checks++; if (instr_o !== 32'h13) begin n_fails++; $display("FAIL reset_instr: got %h want 00000013", instr_o); end
        n_checks++; if (pc_o !== 32'h0) begin n_fails++; $display("FAIL reset_pc: got %h want 0", pc_o); end
        n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin n_fails++; $display("FAIL reset_req: got req=%b addr=%h want 1/0", imem_req_o, imem_addr_o); end
    endtask

    task automatic test_stream();
        do_reset();
        imem_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'(4*i)) begin n_fails++; $display("FAIL stream_req%0d: got req=%b addr=%h want 1/%h", i, imem_req_o, imem_addr_o, 4*i); end
            tick();
            n_checks++; if (valid_o !== 1'b0 || instr_o !== 32'h13 || imem_req_o !== 1'b0) begin n_fails++; $display("FAIL stream_gap%0d: got v=%b instr=%h req=%b want 0/00000013/0", i, valid_o, instr_o, imem_req_o); end
            imem_valid_i = 1'b1; imem_rdata_i = 32'hA000_0000 + 32'(i);
            tick();
            imem_valid_i = 1'b0; #1;
            n_checks++; if (valid_o !== 1'b1 || pc_o !== 32'(4*i) || instr_o !== 32'hA000_0000 + 32'(i)) begin n_fails++; $display("FAIL stream_slot%0d: got v=%b pc=%h instr=%h want 1/%h/%h", i, valid_o, pc_o, instr_o, 4*i, 32'hA000_0000 + 32'(i)); end
        end
    endtask

    task automatic test_stall_full();
        do_reset();
        imem_ready_i = 1'b1;
        tick();
        imem_valid_i = 1'b1; imem_rdata_i = 32'hCAFE_0000;
        tick();
        imem_valid_i = 1'b0; stall_i = 1'b1;
        tick();
        imem_valid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
        tick();
        imem_valid_i = 1'b0; #1;
        n_checks++; if (valid_o !== 1'b1 || instr_o !== 32'hCAFE_0000 || pc_o !== 32'h0) begin n_fails++; $display("FAIL stall_hold: got v=%b instr=%h pc=%h want 1/cafe0000/0", valid_o, instr_o, pc_o); end
        n_checks++; if (imem_req_o !== 1'b0) begin n_fails++; $display("FAIL stall_full_noreq: got %b want 0", imem_req_o); end
        tick();
        n_checks++; if (instr_o !== 32'hCAFE_0000) begin n_fails++; $display("FAIL stall_hold2: got %h want cafe0000", instr_o); end
        stall_i = 1'b0;
        tick();
        n_checks++; if (valid_o !== 1'b1 || instr_o !== 32'hDEAD_BEEF || pc_o !== 32'h4) begin n_fails++; $display("FAIL stall_release: got v=%b instr=%h pc=%h want 1/deadbeef/4", valid_o, instr_o, pc_o); end
        n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin n_fails++; $display("FAIL stall_nextreq: got req=%b addr=%h want 1/8", imem_req_o, imem_addr_o); end
    endtask

    task automatic test_branch_wait();
        do_reset();
        imem_ready_i = 1'b1;
        tick();
        imem_ready_i = 1'b0; branch_i = 1'b1; branch_target_i = 32'h0000_0103; #1;
        n_checks++; if (flush_o !== 1'b1 || imem_req_o !== 1'b0) begin n_fails++; $display("FAIL br_flush_on: got flush=%b req=%b want 1/0", flush_o, imem_req_o); end
        tick();
        branch_i = 1'b0; #1;
        n_checks++; if (flush_o !== 1'b0 || imem_req_o !== 1'b0) begin n_fails++; $display("FAIL br_flush_off: got flush=%b req=%b want 0/0", flush_o, imem_req_o); end
        tick(); tick();
        imem_valid_i = 1'b1; imem_rdata_i = 32'h1111_1111;
        tick();
        imem_valid_i = 1'b0; imem_ready_i = 1'b1; #1;
        n_checks++; if (valid_o !== 1'b0 || instr_o !== 32'h13) begin n_fails++; $display("FAIL br_discard: got v=%b instr=%h want 0/00000013", valid_o, instr_o); end
        n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin n_fails++; $display("FAIL br_target_req: got req=%b addr=%h want 1/100", imem_req_o, imem_addr_o); end
    endtask

    task automatic test_branch_valid_same();
        do_reset();
        imem_ready_i = 1'b1;
        tick();
        imem_valid_i = 1'b1; imem_rdata_i = 32'h5555_5555;
        tick();
        imem_valid_i = 1'b0; stall_i = 1'b1;
        tick();
        branch_i = 1'b1; branch_target_i = 32'h200; imem_valid_i = 1'b1; imem_rdata_i = 32'h2222_2222;
        tick();
        branch_i = 1'b0; imem_valid_i = 1'b0; stall_i = 1'b0; #1;
        n_checks++; if (valid_o !== 1'b0 || instr_o !== 32'h13 || pc_o !== 32'h0) begin n_fails++; $display("FAIL brv_bubble: got v=%b instr=%h pc=%h want 0/00000013/0", valid_o, instr_o, pc_o); end
        n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin n_fails++; $display("FAIL brv_req: got req=%b addr=%h want 1/200", imem_req_o, imem_addr_o); end
        tick();
        imem_valid_i = 1'b1; imem_rdata_i = 32'h3333_3333;
        tick();
        imem_valid_i = 1'b0; #1;
        n_checks++; if (valid_o !== 1'b1 || instr_o !== 32'h3333_3333 || pc_o !== 32'h200) begin n_fails++; $display("FAIL brv_nokill: got v=%b instr=%h pc=%h want 1/33333333/200", valid_o, instr_o, pc_o); end
    endtask

    task automatic test_wrap();
        do_reset();
        branch_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
        tick();
        branch_i = 1'b0; #1;
        n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFFC) begin n_fails++; $display("FAIL wrap_req: got req=%b addr=%h want 1/fffffffc", imem_req_o, imem_addr_o); end
        tick();
        n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFFC) begin n_fails++; $display("FAIL addr_stable: got req=%b addr=%h want 1/fffffffc", imem_req_o, imem_addr_o); end
        imem_ready_i = 1'b1;
        tick();
        imem_ready_i = 1'b0; imem_valid_i = 1'b1; imem_rdata_i = 32'h0000_0044;
        tick();
        imem_valid_i = 1'b0; #1;
        n_checks++; if (pc_o !== 32'hFFFF_FFFC || valid_o !== 1'b1) begin n_fails++; $display("FAIL wrap_slot: got v=%b pc=%h want 1/fffffffc", valid_o, pc_o); end
        n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin n_fails++; $display("FAIL wrap_next: got req=%b addr=%h want 1/0", imem_req_o, imem_addr_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        imem_ready_i = 1'b1;
        tick();
        imem_valid_i = 1'b1; imem_rdata_i = 32'h7777_7777;
        tick();
        imem_valid_i = 1'b0; stall_i = 1'b1;
        tick();
        imem_ready_i = 1'b0; #2;
        n_checks++; if (valid_o !== 1'b1 || imem_req_o !== 1'b0) begin n_fails++; $display("FAIL rmid_pre: got v=%b req=%b want 1/0", valid_o, imem_req_o); end
        rst_i = 1'b1; #1;
        n_checks++; if (valid_o !== 1'b0 || instr_o !== 32'h13 || pc_o !== 32'h0) begin n_fails++; $display("FAIL rmid_async: got v=%b instr=%h pc=%h want 0/00000013/0", valid_o, instr_o, pc_o); end
        n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin n_fails++; $display("FAIL rmid_addr: got req=%b addr=%h want 1/0", imem_req_o, imem_addr_o); end
        stall_i = 1'b0;
        tick();
        rst_i = 1'b0; imem_valid_i = 1'b1; imem_rdata_i = 32'h9999_9999;
        tick();
        imem_valid_i = 1'b0; #1;
        n_checks++; if (valid_o !== 1'b0 || instr_o !== 32'h13) begin n_fails++; $display("FAIL rmid_late: got v=%b instr=%h want 0/00000013", valid_o, instr_o); end
        n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin n_fails++; $display("FAIL rmid_firstreq: got req=%b addr=%h want 1/0", imem_req_o, imem_addr_o); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_full();
        test_branch_wait();
        test_branch_valid_same();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage that owns the program counter and issues fetch requests to instruction memory over a ready/valid handshake with one outstanding request. Returned instructions go into a registered output slot that feeds the IF/ID pipeline register (`instr_o`/`pc_o` into its `instr_i`/`pc_i`). The block honours the hazard-unit stall and the ID-stage branch redirect, and generates the IF/ID flush.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP`, default 32'h0000_0013: bubble encoding presented when the slot is empty.

Ports:
- `clk_i`, in, 1: single clock, rising edge.
- `rst_i`, in, 1: reset, asynchronous and active-high.
- `stall_i`, in, 1: hazard stall; output slot must hold.
- `branch_i`, in, 1: redirect from ID, single-cycle pulse.
- `branch_target_i`, in, 32: redirect address; bits [1:0] forced to 00.
- `imem_req_o`, out, 1: fetch request valid.
- `imem_addr_o`, out, 32: fetch address.
- `imem_ready_i`, in, 1: memory accepts the request this cycle.
- `imem_valid_i`, in, 1: response valid.
- `imem_rdata_i`, in, 32: response instruction.
- `instr_o`, out, 32: instruction to IF/ID.
- `pc_o`, out, 32: PC of `instr_o`.
- `valid_o`, out, 1: slot holds a real instruction.
- `flush_o`, out, 1: IF/ID flush, equal to `branch_i` (combinational).

## Operation
- Registers:
  - `pc_q`: next fetch address.
  - `issued_pc_q`: address in flight.
  - `kill_q`: drop the in-flight response.
  - FSM state: REQ, WAIT, FULL.
  - One-entry buffer holding `buf_instr` and `buf_pc`.
  - Output slot holding `valid_o`, `instr_o` and `pc_o`.
- Reset values:
  - `pc_q` = `RESET_PC`, state = REQ, `kill_q` = 0, buffer empty.
  - `valid_o` = 0, `instr_o` = `NOP`, `pc_o` = 0.
- REQ state:
  - `imem_req_o` = `!branch_i`; `imem_addr_o` = `pc_q`.
  - On `imem_req_o && imem_ready_i`: `issued_pc_q` <= `pc_q`, `pc_q` <= `pc_q` + 4 (mod 2^32, wraps silently), go to WAIT.
  - `imem_valid_i` is ignored in REQ (stale responses across reset are dropped).
- WAIT state:
  - `imem_req_o` = 0.
  - On `imem_valid_i` with `kill_q` = 1: discard the response, clear `kill_q`, go to REQ.
  - On `imem_valid_i` when the slot is free (`!valid_o || !stall_i`): load the slot with `{1, rdata, issued_pc_q}` and go to REQ.
  - On `imem_valid_i` otherwise: write the buffer and go to FULL.
- FULL state:
  - `imem_req_o` = 0.
  - On `!stall_i`: move the buffer into the slot, go to REQ.
- Slot update:
  - When `!stall_i` and nothing loads into the slot, it becomes a bubble: `valid_o` = 0, `instr_o` = `NOP`, `pc_o` = 0.
  - While `stall_i` = 1 (and no redirect), the slot holds its value.
- Redirect (`branch_i` = 1) has priority over everything, including `stall_i`:
  - `pc_q` <= target; the slot becomes a bubble; the buffer is dropped.
  - From REQ or FULL, go to REQ. No request issues this cycle because `imem_req_o` is masked.
  - From WAIT with no `imem_valid_i` this cycle: stay in WAIT with `kill_q` <= 1.
  - From WAIT with `imem_valid_i` this cycle: discard the response, go to REQ with `kill_q` = 0.
- Reset asserted mid-operation returns every register to its reset value immediately, regardless of any in-flight memory transaction.

## Timing
- Best-case throughput, with zero-wait memory (ready in REQ, valid the next cycle): one instruction every 2 cycles.
- Latency: a response at edge N appears on the slot outputs after edge N.
- Redirect penalty: the first target request asserts the cycle after `branch_i`. If a request is in flight, the target request waits until that killed response returns.
- `flush_o` is a zero-cycle passthrough of `branch_i`, so IF/ID clears the wrong-path instruction on the same edge.
- `imem_addr_o` is stable while `imem_req_o` = 1 and `imem_ready_i` = 0.

## Structure
- Shared package `fetch_pkg`:
  - State enum `fetch_state_e` {REQ, WAIT, FULL}.
  - `NOP_INSTR` = 32'h0000_0013.
  - `XLEN` = 32.
  - `PC_STEP` = 4.
- Single module; no sub-module. The one-entry buffer stays inline.

## Test plan
- Reset release, memory always ready, response 1 cycle later:
  - First request address is 0x0.
  - Slot shows pc 0x0, then 0x4, then 0x8, one instruction every 2 cycles.
  - Before the first response, `valid_o` = 0 and `instr_o` = 0x00000013.
- Response 0xDEADBEEF arrives while `valid_o` = 1 and `stall_i` = 1:
  - FSM enters FULL and the slot holds.
  - When stall drops, the slot shows 0xDEADBEEF one cycle later, then a request for the next pc issues.
- `branch_i` pulse with target 0x100 while in WAIT; response 0x11111111 arrives 3 cycles later:
  - The response is discarded.
  - The next request address is 0x100.
  - `flush_o` is high for exactly the branch cycle.
- `branch_i` and `imem_valid_i` in the same cycle:
  - The response is dropped and `kill_q` stays 0.
  - The next request address is the target; the slot becomes a bubble.
- `pc_q` = 0xFFFFFFFC is issued:
  - The next request address is 0x00000000.
- `rst_i` asserted while in WAIT, then a late `imem_valid_i`:
  - All outputs return to reset values asynchronously.
  - The late response is ignored; the first post-reset request address is `RESET_PC`.
